counter_rr_sched: RTL and testbench

- Round-robin scheduler that shares one CW-bit up-counter among NREQ requesters.
- Each requester asks for a count run to its own terminal value. The scheduler grants exactly one requester, clears and runs the counter, then pulses done to that requester when the terminal value is reached.
- Sits between requesting control blocks and the shared counting datapath; the counter is internal, and its value is exported.

---
 rtl/counter_rr_sched.sv | 148 ++++++++++++++
 tb/tb_counter_rr_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_rr_sched.sv
// Round-robin scheduler sharing one up-counter among NREQ requesters.
// Grants one requester at a time, counts to its latched target, then pulses done.
module counter_rr_sched #(
   parameter int NREQ = 4,
   parameter int CW   = 4,
   parameter int IDW  = 2
) (
   input  logic                 CLK,
   input  logic                 CLR,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*CW-1:0]   tgt,
   output logic [NREQ-1:0]      gnt,
   output logic [IDW-1:0]       gnt_id,
   output logic                 busy,
   output logic [NREQ-1:0]      done,
   output logic [CW-1:0]        COUNT
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IDW-1:0]  gnt_id_q, gnt_id_d;
   logic [CW-1:0]   tgt_q, tgt_d;
   logic [CW-1:0]   count_q, count_d;
   logic [NREQ-1:0] done_q, done_d;
   logic            busy_q, busy_d;

   logic [CW-1:0]   tgt_s [NREQ];
   logic            sel_vld_s;
   logic [IDW-1:0]  sel_id_s;
   logic [IDW-1:0]  nxt_ptr_s;

   // Split the flat target bus into per-requester slices
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         tgt_s[i] = tgt[i*CW +: CW];
      end
   end

   // Scan descending so the requester closest to ptr wins last
   always_comb begin : p_sel
      logic [IDW-1:0] idx;
      sel_vld_s = 1'b0;
      sel_id_s  = '0;
      idx       = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = IDW'((int'(ptr_q) + k) % NREQ);
         if (req[idx]) begin
            sel_vld_s = 1'b1;
            sel_id_s  = idx;
         end else begin
            sel_vld_s = sel_vld_s;
         end
      end
   end

   // Rotate priority past the requester just served
   always_comb begin
      if (gnt_id_q == IDW'(NREQ - 1)) begin
         nxt_ptr_s = '0;
      end else begin
         nxt_ptr_s = gnt_id_q + IDW'(1);
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      tgt_d    = tgt_q;
      count_d  = count_q;
      done_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (sel_vld_s) begin
               gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << sel_id_s;
               gnt_id_d = sel_id_s;
               tgt_d    = tgt_s[sel_id_s];
               count_d  = '0;
               state_d  = ST_RUN;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Abort outranks a terminal match on the same edge
            if (!req[gnt_id_q]) begin
               gnt_d   = '0;
               ptr_d   = nxt_ptr_s;
               state_d = ST_IDLE;
            end else if (count_q == tgt_q) begin
               gnt_d   = '0;
               done_d  = gnt_q;
               state_d = ST_DONE;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         ST_DONE: begin
            ptr_d   = nxt_ptr_s;
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         tgt_q    <= '0;
         count_q  <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         tgt_q    <= tgt_d;
         count_q  <= count_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign COUNT  = count_q;

endmodule

// File: tb/tb_counter_rr_sched.sv
// Scoreboard bench: stimulus queues expected per-cycle activity, a monitor
// pops and compares every cycle the scheduler shows busy, grant or done.
module tb_counter_rr_sched;

   logic        CLK;
   logic        CLR;
   logic [3:0]  req;
   logic [15:0] tgt;
   logic [3:0]  gnt;
   logic [1:0]  gnt_id;
   logic        busy;
   logic [3:0]  done;
   logic [3:0]  COUNT;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] gid;
      logic [3:0] done;
      logic [3:0] cnt;
      logic       busy;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   counter_rr_sched #(.NREQ(4), .CW(4), .IDW(2)) dut (
      .CLK   (CLK),
      .CLR   (CLR),
      .req   (req),
      .tgt   (tgt),
      .gnt   (gnt),
      .gnt_id(gnt_id),
      .busy  (busy),
      .done  (done),
      .COUNT (COUNT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Queue one run: grant cycles with COUNT 0..last, then optional done cycle
   task automatic push_run(input int id, input int t, input int last, input bit with_done);
      exp_t e;
      logic [3:0] oh;
      oh = 4'b0001 << id;
      for (int k = 0; k <= last; k++) begin
         e.gnt = oh; e.gid = 2'(id); e.done = 4'b0000; e.cnt = 4'(k); e.busy = 1'b1;
         q.push_back(e);
      end
      if (with_done) begin
         e.gnt = 4'b0000; e.gid = 2'(id); e.done = oh; e.cnt = 4'(t); e.busy = 1'b1;
         q.push_back(e);
      end
   endtask

   task automatic drain(input string tag);
      int c;
      c = 0;
      while (q.size() != 0 && c < 300) begin
         @(negedge CLK);
         #1;
         c++;
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL %s: timeout with %0d entries left, required 0", tag, q.size());
         q.delete();
      end
   endtask

   task automatic check_zero(input string tag);
      n_cmp++;
      if (gnt !== 4'b0000 || done !== 4'b0000 || COUNT !== 4'd0 || busy !== 1'b0 || gnt_id !== 2'd0) begin
         n_err++;
         $display("FAIL %s: gnt=%b done=%b cnt=%0d busy=%b id=%0d, required all zero",
                  tag, gnt, done, COUNT, busy, gnt_id);
      end
   endtask

   // Monitor: compare each active cycle against the scoreboard
   initial begin : monitor
      exp_t e;
      exp_t a;
      bit   prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge CLK);
         if (prev_done) begin
            n_cmp++;
            if (busy !== 1'b0 || gnt !== 4'b0000) begin
               n_err++;
               $display("FAIL post_done_idle: busy=%b gnt=%b, required busy=0 gnt=0000", busy, gnt);
            end
         end
         prev_done = (done != 4'b0000);
         if (busy || gnt != 4'b0000 || done != 4'b0000) begin
            a.gnt = gnt; a.gid = gnt_id; a.done = done; a.cnt = COUNT; a.busy = busy;
            n_cmp++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_activity: gnt=%b id=%0d done=%b cnt=%0d busy=%b, required nothing",
                        gnt, gnt_id, done, COUNT, busy);
            end else begin
               e = q.pop_front();
               if (a !== e) begin
                  n_err++;
                  $display("FAIL cycle: got gnt=%b id=%0d done=%b cnt=%0d busy=%b, required gnt=%b id=%0d done=%b cnt=%0d busy=%b",
                           a.gnt, a.gid, a.done, a.cnt, a.busy, e.gnt, e.gid, e.done, e.cnt, e.busy);
               end
            end
         end
      end
   end

   initial begin : stim
      CLR = 1'b1;
      req = 4'b0000;
      tgt = 16'h0000;
      repeat (2) @(negedge CLK);
      check_zero("reset_state");
      #1 CLR = 1'b0;
      repeat (3) @(negedge CLK);

      // Reset pulse mid-cycle, outputs checked before the next edge
      #2 CLR = 1'b1;
      #1 check_zero("clr_idle");
      @(negedge CLK);
      #1 CLR = 1'b0;
      @(negedge CLK);
      #1;

      // Round robin with all requesters, all targets 0
      push_run(0, 0, 0, 1'b1);
      push_run(1, 0, 0, 1'b1);
      push_run(2, 0, 0, 1'b1);
      push_run(3, 0, 0, 1'b1);
      push_run(0, 0, 0, 1'b1);
      tgt = 16'h0000;
      req = 4'b1111;
      drain("round_robin");
      req = 4'b0000;
      repeat (3) @(negedge CLK);
      #1;

      // Single run, requester 1 target 3
      tgt[7:4] = 4'd3;
      push_run(1, 3, 3, 1'b1);
      req = 4'b0010;
      drain("single_run");
      req = 4'b0000;
      repeat (3) @(negedge CLK);
      #1;

      // Abort requester 2 at COUNT 4 while 3 and 0 wait
      tgt[11:8]  = 4'd9;
      tgt[15:12] = 4'd1;
      tgt[3:0]   = 4'd15;
      push_run(2, 9, 4, 1'b0);
      req = 4'b1101;
      drain("abort_pre");
      req = 4'b1001;
      push_run(3, 1, 1, 1'b1);
      drain("after_abort");

      // Boundary target 15 for requester 0, target change mid-run ignored
      push_run(0, 15, 15, 1'b1);
      req = 4'b0001;
      repeat (4) @(negedge CLK);
      #1 tgt[3:0] = 4'd2;
      drain("boundary");
      req = 4'b0000;
      repeat (3) @(negedge CLK);
      #1;

      // Reset at COUNT 5 during a run, then restart from pointer 0
      tgt[7:4] = 4'd9;
      push_run(1, 9, 5, 1'b0);
      req = 4'b0010;
      drain("pre_reset_run");
      CLR = 1'b1;
      #1 check_zero("clr_midrun");
      req = 4'b1001;
      tgt[3:0]   = 4'd0;
      tgt[15:12] = 4'd0;
      repeat (2) @(negedge CLK);
      push_run(0, 0, 0, 1'b1);
      #1 CLR = 1'b0;
      drain("post_reset_grant");
      req = 4'b0000;
      repeat (6) @(negedge CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
